// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, derived totals and sync-window helpers
package vga_timing_pkg;

    localparam int CNT_W     = 12;
    localparam int CNT_LIMIT = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int scan_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    function automatic int sync_end(input int act, input int fp, input int sync);
        return act + fp + sync;
    endfunction

    localparam int DEF_H_TOTAL      = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL      = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
    localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

    // Half-open window test done in int so a bound of 4096 is still representable.
    function automatic logic in_range(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
        int c;
        c = int'(cnt);
        return (c >= lo) && (c < hi);
    endfunction

    typedef struct packed {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             active;
        logic             hsync;
        logic             vsync;
    } scan_decode_t;

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - enabled modulo counter with combinational wrap flag
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = DEF_H_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

    if (MODULUS < 1 || MODULUS > CNT_LIMIT) begin : g_bad_modulus
        $error("scan_counter: MODULUS out of 12-bit range");
    end

    // Wrap reflects the count alone so a downstream counter can chain on en & wrap.
    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan generator with registered decode and frame counter
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL      = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = sync_start(H_ACTIVE, H_FP);
    localparam int H_SYNC_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int V_SYNC_START = sync_start(V_ACTIVE, V_FP);
    localparam int V_SYNC_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam bit SYNC_IDLE    = ~SYNC_ACT;

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_timing
        $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_en;
    logic             at_origin;
    logic             first_done;
    scan_decode_t     dec;

    assign v_en = pix_en & h_wrap;

    scan_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    scan_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    always_comb begin
        dec        = '0;
        dec.x      = h_cnt;
        dec.y      = v_cnt;
        dec.active = in_range(h_cnt, 0, H_ACTIVE) && in_range(v_cnt, 0, V_ACTIVE);
        dec.hsync  = in_range(h_cnt, H_SYNC_START, H_SYNC_END) ? SYNC_ACT : SYNC_IDLE;
        dec.vsync  = in_range(v_cnt, V_SYNC_START, V_SYNC_END) ? SYNC_ACT : SYNC_IDLE;
    end

    // Tracks (h_cnt, v_cnt) == (0, 0) one step ahead, from the chained wrap flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            at_origin <= 1'b1;
        end else if (pix_en) begin
            at_origin <= h_wrap & v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            first_done  <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x           <= dec.x;
                y           <= dec.y;
                active      <= dec.active;
                hsync       <= dec.hsync;
                vsync       <= dec.vsync;
                line_start  <= (h_cnt == '0);
                frame_start <= at_origin;
                // The first frame after reset keeps frame_cnt at zero.
                if (at_origin) begin
                    first_done <= 1'b1;
                    if (first_done) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - scoreboard bench for vga_scan_gen, default and small timings
module tb_vga_scan_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        active;
        logic        hsync;
        logic        vsync;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    logic [11:0] x_a, y_a, x_b, y_b;
    logic        active_a, hsync_a, vsync_a, ls_a, fs_a;
    logic        active_b, hsync_b, vsync_b, ls_b, fs_b;
    logic [7:0]  fc_a, fc_b;

    int checks = 0;
    int failures = 0;
    int nfs_b = 0;

    obs_t   q_a[$];
    obs_t   q_b[$];
    longint p_a = 0;
    longint p_b = 0;
    obs_t   last_a;
    obs_t   last_b;

    always #5 clk = ~clk;

    vga_scan_gen dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x_a), .y(y_a), .active(active_a), .hsync(hsync_a), .vsync(vsync_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_scan_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACT(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x_b), .y(y_b), .active(active_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    // Pixel p of the raster since reset, evaluated straight from the timing numbers.
    function automatic obs_t model(input longint p, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input logic sa);
        obs_t o;
        longint ht, vt, h, v, f;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        f  = p / (ht * vt);
        o.x      = 12'(h);
        o.y      = 12'(v);
        o.active = (h < ha) && (v < va);
        o.hsync  = (h >= ha + hf && h < ha + hf + hs) ? sa : ~sa;
        o.vsync  = (v >= va + vf && v < va + vf + vs) ? sa : ~sa;
        o.ls     = (h == 0);
        o.fs     = (h == 0) && (v == 0);
        o.fc     = 8'(f % 256);
        return o;
    endfunction

    function automatic obs_t reset_obs(input logic sa);
        obs_t o;
        o = '0;
        o.hsync = ~sa;
        o.vsync = ~sa;
        return o;
    endfunction

    task automatic report(input string name, input obs_t got, input obs_t exp);
        $display("FAIL %s got/exp x=%0d/%0d y=%0d/%0d act=%0b/%0b hs=%0b/%0b vs=%0b/%0b ls=%0b/%0b fs=%0b/%0b fc=%0d/%0d",
                 name, got.x, exp.x, got.y, exp.y, got.active, exp.active, got.hsync, exp.hsync,
                 got.vsync, exp.vsync, got.ls, exp.ls, got.fs, exp.fs, got.fc, exp.fc);
    endtask

    function automatic obs_t obs_a();
        return {x_a, y_a, active_a, hsync_a, vsync_a, ls_a, fs_a, fc_a};
    endfunction

    function automatic obs_t obs_b();
        return {x_b, y_b, active_b, hsync_b, vsync_b, ls_b, fs_b, fc_b};
    endfunction

    task automatic directed(input string name, input obs_t exp);
        obs_t got;
        got = obs_a();
        checks++;
        if (got !== exp) begin
            failures++;
            report(name, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic rst);
        pix_en = en;
        reset  = rst;
        if (rst) begin
            p_a = 0;
            p_b = 0;
            last_a = reset_obs(1'b0);
            last_b = reset_obs(1'b1);
            nfs_b = 0;
        end else if (en) begin
            last_a = model(p_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            last_b = model(p_b, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1);
            p_a++;
            p_b++;
        end else begin
            last_a.ls = 1'b0; last_a.fs = 1'b0;
            last_b.ls = 1'b0; last_b.fs = 1'b0;
        end
        q_a.push_back(last_a);
        q_b.push_back(last_b);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                g = obs_a();
                checks++;
                if (g !== e) begin
                    failures++;
                    report("scan_a", g, e);
                end
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                g = obs_b();
                checks++;
                if (g !== e) begin
                    failures++;
                    report("scan_b", g, e);
                end
                if (e.fs) begin
                    nfs_b++;
                    if (nfs_b == 257) begin
                        checks++;
                        if (fc_b !== 8'd0) begin
                            failures++;
                            $display("FAIL frame_cnt_wrap got=%0d exp=0", fc_b);
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        obs_t exp;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        directed("reset_state", '{x:12'd0, y:12'd0, active:1'b0, hsync:1'b1, vsync:1'b1,
                                  ls:1'b0, fs:1'b0, fc:8'd0});

        step(1'b1, 1'b0);
        directed("first_pixel", '{x:12'd0, y:12'd0, active:1'b1, hsync:1'b1, vsync:1'b1,
                                  ls:1'b1, fs:1'b1, fc:8'd0});
        repeat (799) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        directed("second_line", '{x:12'd0, y:12'd1, active:1'b1, hsync:1'b1, vsync:1'b1,
                                  ls:1'b1, fs:1'b0, fc:8'd0});
        repeat (1610) step(1'b1, 1'b0);

        for (int i = 0; i < 400; i++) step(i % 2 == 0, 1'b0);
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0, 1'b0);

        step($urandom_range(0, 1) != 0, 1'b1);
        directed("mid_frame_reset", '{x:12'd0, y:12'd0, active:1'b0, hsync:1'b1, vsync:1'b1,
                                      ls:1'b0, fs:1'b0, fc:8'd0});
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        directed("restart_origin", '{x:12'd0, y:12'd0, active:1'b1, hsync:1'b1, vsync:1'b1,
                                     ls:1'b1, fs:1'b1, fc:8'd0});

        repeat (21700) step(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) step($urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);

        pix_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q_a.size(), q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
